// File: rtl/scm_ctrl.sv
// Sequencing controller for the latch-based scm LUT store: serialises writes into
// issue/commit pairs, runs a hardware clear sweep and pipelines reads with a RAW stall.
module scm_ctrl #(
    parameter int C             = 32,
    parameter int K             = 16,
    parameter int DataTypeWidth = 16,
    parameter int AddrWidth     = $clog2(C * K)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     init_i,
    output logic                     busy_o,
    output logic                     init_done_o,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [AddrWidth-1:0]     wr_addr_i,
    input  logic [DataTypeWidth-1:0] wr_data_i,
    input  logic                     rd_valid_i,
    output logic                     rd_ready_o,
    input  logic [AddrWidth-1:0]     rd_addr_i,
    output logic                     rd_data_valid_o,
    output logic [DataTypeWidth-1:0] rd_data_o,
    output logic [AddrWidth-1:0]     scm_waddr_o,
    output logic [DataTypeWidth-1:0] scm_wdata_o,
    output logic                     scm_we_o,
    output logic [AddrWidth-1:0]     scm_raddr_o,
    input  logic [DataTypeWidth-1:0] scm_rdata_i,
    output logic [2:0]               dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WR_ISSUE    = 3'd1,
        WR_COMMIT   = 3'd2,
        INIT_ISSUE  = 3'd3,
        INIT_COMMIT = 3'd4
    } state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(C * K - 1);

    state_e                     state_q, state_d;
    logic [AddrWidth-1:0]       waddr_q, waddr_d;
    logic [DataTypeWidth-1:0]   wdata_q, wdata_d;
    logic [AddrWidth-1:0]       cnt_q, cnt_d;
    logic                       pend_q, pend_d;
    logic                       done_q, done_d;

    logic [AddrWidth-1:0]       raddr_q;
    logic                       rv1_q, rv2_q;
    logic [DataTypeWidth-1:0]   rdata_q;

    logic                       wr_ready;
    logic                       rd_ready;
    logic                       rd_fire;
    logic                       wr_active;
    logic                       init_active;

    // Handshakes: a request transfers on the rising edge where valid and ready are
    // both high; ready never depends on valid, and valid may be held across stalls.
    // A pending or same-cycle init drops wr_ready so a visible handshake is always
    // an accepted write.
    assign wr_active   = (state_q == WR_ISSUE) || (state_q == WR_COMMIT);
    assign init_active = (state_q == INIT_ISSUE) || (state_q == INIT_COMMIT);

    assign wr_ready = rst_ni && (state_q == IDLE) && !init_i && !pend_q;
    assign rd_ready = rst_ni && !init_active && !(wr_active && (rd_addr_i == waddr_q));
    assign rd_fire  = rd_valid_i && rd_ready;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_i || pend_q) begin
                    state_d = INIT_ISSUE;
                    cnt_d   = '0;
                    waddr_d = '0;
                    wdata_d = '0;
                    pend_d  = 1'b0;
                end else if (wr_valid_i && wr_ready) begin
                    state_d = WR_ISSUE;
                    waddr_d = wr_addr_i;
                    wdata_d = wr_data_i;
                end
            end
            WR_ISSUE: begin
                state_d = WR_COMMIT;
                if (init_i) pend_d = 1'b1;
            end
            WR_COMMIT: begin
                state_d = IDLE;
                if (init_i) pend_d = 1'b1;
            end
            INIT_ISSUE: begin
                state_d = INIT_COMMIT;
            end
            INIT_COMMIT: begin
                if (cnt_q == LastAddr) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = INIT_ISSUE;
                    cnt_d   = cnt_q + AddrWidth'(1);
                    waddr_d = cnt_q + AddrWidth'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Read pipeline: address register, then data capture; reads in flight are
    // never cancelled by a sweep that starts behind them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            raddr_q <= '0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (rd_fire) raddr_q <= rd_addr_i;
            rv1_q <= rd_fire;
            rv2_q <= rv1_q;
            if (rv1_q) rdata_q <= scm_rdata_i;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign init_done_o     = done_q;
    assign wr_ready_o      = wr_ready;
    assign rd_ready_o      = rd_ready;
    assign rd_data_valid_o = rv2_q;
    assign rd_data_o       = rdata_q;
    assign scm_waddr_o     = waddr_q;
    assign scm_wdata_o     = wdata_q;
    assign scm_we_o        = (state_q == WR_ISSUE) || (state_q == INIT_ISSUE);
    assign scm_raddr_o     = raddr_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_scm_ctrl.sv
// Bench for scm_ctrl: a behavioural scm (write committed one edge after sampling),
// read scoreboard with expected-data and latency queues, directed protocol checks.
module tb_scm_ctrl;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          init_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          rd_valid_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          busy_o, init_done_o, wr_ready_o, rd_ready_o, rd_data_valid_o, scm_we_o;
    logic [DW-1:0] rd_data_o, scm_wdata_o, scm_rdata;
    logic [AW-1:0] scm_waddr_o, scm_raddr_o;
    logic [2:0]    dbg_state_o;

    scm_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni), .init_i(init_i), .busy_o(busy_o),
        .init_done_o(init_done_o), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_valid_i(rd_valid_i),
        .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i), .rd_data_valid_o(rd_data_valid_o),
        .rd_data_o(rd_data_o), .scm_waddr_o(scm_waddr_o), .scm_wdata_o(scm_wdata_o),
        .scm_we_o(scm_we_o), .scm_raddr_o(scm_raddr_o), .scm_rdata_i(scm_rdata),
        .dbg_state_o(dbg_state_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scm model: data sampled on the we edge, visible after the following edge
    logic [DW-1:0] scm_mem [N];
    logic          filled = 1'b0;
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < N; i++) scm_mem[i] <= DW'($urandom);
            filled <= 1'b1;
        end else if (pend_v) begin
            scm_mem[pend_a] <= pend_d;
        end
        pend_v <= scm_we_o;
        pend_a <= scm_waddr_o;
        pend_d <= scm_wdata_o;
    end
    assign scm_rdata = scm_mem[scm_raddr_o];

    // scoreboard
    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] exp_q[$];
    int            lat_q[$];
    logic [DW-1:0] ref_mem [N];
    int            vrun = 0;
    int            vrun_max = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rd_data_valid_o) begin
            vrun = vrun + 1;
            if (vrun > vrun_max) vrun_max = vrun;
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 64'(1), 64'(0));
            end else begin
                check("rd_data", 64'(rd_data_o), 64'(exp_q.pop_front()));
                check("rd_latency", 64'(cyc - lat_q.pop_front()), 64'(2));
            end
        end else begin
            vrun = 0;
        end
    end

    // driver tasks
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int guard = 0;
        wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        #1;
        while (!wr_ready_o && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) check("wr_timeout", 64'(0), 64'(1));
        else ref_mem[a] = d;
        @(negedge clk);
        wr_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int guard = 0;
        rd_valid_i = 1'b1; rd_addr_i = a;
        #1;
        while (!rd_ready_o && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) check("rd_timeout", 64'(0), 64'(1));
        else begin
            exp_q.push_back(ref_mem[a]);
            lat_q.push_back(cyc);
        end
        @(negedge clk);
        rd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            @(negedge clk); g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_sweep(input string tag);
        int busy_n = 0;
        int done_n = 0;
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            busy_n += int'(busy_o);
            done_n += int'(init_done_o);
            if (i == 5) begin
                check({tag, "_wr_ready_sweep"}, 64'(wr_ready_o), 64'(0));
                check({tag, "_rd_ready_sweep"}, 64'(rd_ready_o), 64'(0));
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(1024));
        check({tag, "_done_pulses"}, 64'(done_n), 64'(1));
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
    endtask

    initial begin
        logic [5:0] exp_rdy;
        logic [5:0] exp_we;
        int done_n;
        exp_rdy = 6'b100100;
        exp_we  = 6'b010010;

        // reset
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({busy_o, init_done_o, wr_ready_o, rd_ready_o, rd_data_valid_o,
                                    rd_data_o, scm_waddr_o, scm_wdata_o, scm_we_o, scm_raddr_o}), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk);
        check("idle_wr_ready", 64'(wr_ready_o), 64'(1));
        check("idle_busy", 64'(busy_o), 64'(0));

        // clear sweep and readback
        run_sweep("sweep1");
        do_read(9'd0);
        do_read(9'd255);
        do_read(9'd511);
        drain();

        // write stream with valid held high
        @(negedge clk);
        wr_valid_i = 1'b1; wr_addr_i = 9'h005; wr_data_i = 16'hBEEF;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wr_ready[%0d]", i), 64'(wr_ready_o), 64'(exp_rdy[5-i]));
            check($sformatf("scm_we[%0d]", i), 64'(scm_we_o), 64'(exp_we[5-i]));
            if (i == 1) begin
                check("waddr_issue0", 64'(scm_waddr_o), 64'(9'h005));
                check("wdata_issue0", 64'(scm_wdata_o), 64'(16'hBEEF));
            end
            if (i == 2) check("waddr_parked", 64'(scm_waddr_o), 64'(9'h005));
            if (i == 4) begin
                check("waddr_issue1", 64'(scm_waddr_o), 64'(9'h1FF));
                check("wdata_issue1", 64'(scm_wdata_o), 64'(16'h1234));
            end
            if (wr_ready_o) ref_mem[wr_addr_i] = wr_data_i;
            @(negedge clk);
            if (i == 0) begin
                wr_addr_i = 9'h1FF; wr_data_i = 16'h1234;
            end
            #1;
        end
        wr_valid_i = 1'b0;
        do_read(9'h005);
        do_read(9'h1FF);
        drain();

        // read-after-write stall
        do_write(9'h0A5, 16'hCAFE);
        rd_valid_i = 1'b1; rd_addr_i = 9'h0A5;
        #1;
        check("raw_stall_issue", 64'(rd_ready_o), 64'(0));
        @(negedge clk); #1;
        check("raw_stall_commit", 64'(rd_ready_o), 64'(0));
        @(negedge clk); #1;
        check("raw_release", 64'(rd_ready_o), 64'(1));
        exp_q.push_back(16'hCAFE);
        lat_q.push_back(cyc);
        @(negedge clk);
        rd_valid_i = 1'b0;
        drain();

        // back-to-back reads concurrent with writes elsewhere
        for (int i = 0; i < 8; i++) do_write(AW'(i), DW'($urandom_range(0, 16'hFFFF)));
        repeat (3) @(negedge clk);
        vrun_max = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) do_write(AW'(9'h100 + i), DW'($urandom_range(0, 16'hFFFF)));
            end
            begin
                for (int i = 0; i < 8; i++) do_read(AW'(i));
            end
        join
        drain();
        check("b2b_valid_run", 64'(vrun_max), 64'(8));

        // init during WR_ISSUE: write lands, then sweep clears it
        do_write(9'h033, 16'h7777);
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        @(negedge clk);
        check("write_before_sweep", 64'(scm_mem[9'h033]), 64'(16'h7777));
        done_n = 0;
        for (int i = 0; i < 1200; i++) begin
            done_n += int'(init_done_o);
            @(negedge clk);
        end
        check("pending_sweep_done", 64'(done_n), 64'(1));
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        do_read(9'h033);
        do_read(9'h005);
        drain();

        // reset mid-sweep at counter 300
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        repeat (600) @(negedge clk);
        check("mid_sweep_busy", 64'(busy_o), 64'(1));
        check("mid_sweep_addr", 64'(scm_waddr_o), 64'(300));
        rst_ni = 1'b0;
        @(negedge clk); #1;
        check("reset_mid_sweep", 64'({busy_o, init_done_o, wr_ready_o, rd_ready_o, rd_data_valid_o,
                                      rd_data_o, scm_waddr_o, scm_wdata_o, scm_we_o, scm_raddr_o}), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            done_n += int'(init_done_o);
            @(negedge clk);
        end
        check("no_partial_done", 64'(done_n), 64'(0));
        run_sweep("sweep2");
        do_read(9'd300);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
